// File: rtl/resta_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and the
// default operand width.
package resta_pkg;

  localparam int unsigned RESTA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restcomp.sv
// One-bit full subtractor: Di = xi - yi - bi, Bo = borrow out.
module restcomp (
  input  logic xi,
  input  logic yi,
  input  logic bi,
  output logic Di,
  output logic Bo
);

  // Difference bit and borrow generation/propagation
  assign Di = xi ^ yi ^ bi;
  assign Bo = (~xi & yi) | (~(xi ^ yi) & bi);

endmodule

// File: rtl/resta_serial.sv
// Bit-serial subtractor: D = xi - yi (mod 2^N), one bit per clock, LSB first.
// Handshake: start is sampled only in IDLE; busy is high for exactly N cycles
// while bits are processed; done pulses for one cycle when D/Bo/Z are valid,
// and those outputs then hold until the next done or reset.
// Optional feature: define RESTA_OVF_EN to add the signed-overflow output V.
module resta_serial
  import resta_pkg::*;
#(
  parameter int N = RESTA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] xi,
  input  logic [N-1:0] yi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bo,
  output logic         Z,
`ifdef RESTA_OVF_EN
  output logic         V,
`endif
  output state_t       dbg_state_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [N-1:0]   r_q, r_d;
  logic           b_q, b_d;
  logic [N-1:0]   d_q, d_d;
  logic           bo_q, bo_d;
  logic           z_q, z_d;
`ifdef RESTA_OVF_EN
  // Sign bits of the captured operands; the shift registers lose them.
  logic           xs_q, xs_d;
  logic           ys_q, ys_d;
  logic           v_q, v_d;
`endif

  logic           d_bit;
  logic           b_next;
  logic [N-1:0]   res_shift;

  restcomp u_restcomp (
    .xi (x_q[0]),
    .yi (y_q[0]),
    .bi (b_q),
    .Di (d_bit),
    .Bo (b_next)
  );

  // Result register after this cycle's bit is shifted into the MSB
  always_comb begin
    res_shift        = r_q >> 1;
    res_shift[N-1]   = d_bit;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    b_d     = b_q;
    d_d     = d_q;
    bo_d    = bo_q;
    z_d     = z_q;
`ifdef RESTA_OVF_EN
    xs_d    = xs_q;
    ys_d    = ys_q;
    v_d     = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = xi;
          y_d     = yi;
          r_d     = '0;
          b_d     = 1'b0;
          cnt_d   = '0;
`ifdef RESTA_OVF_EN
          xs_d    = xi[N-1];
          ys_d    = yi[N-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        r_d   = res_shift;
        b_d   = b_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          d_d     = res_shift;
          bo_d    = b_next;
          z_d     = (res_shift == '0);
`ifdef RESTA_OVF_EN
          v_d     = (xs_q ^ ys_q) & (xs_q ^ res_shift[N-1]);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      b_q     <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      z_q     <= 1'b0;
`ifdef RESTA_OVF_EN
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      b_q     <= b_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      z_q     <= z_d;
`ifdef RESTA_OVF_EN
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      v_q     <= v_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign D           = d_q;
  assign Bo          = bo_q;
  assign Z           = z_q;
`ifdef RESTA_OVF_EN
  assign V           = v_q;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_resta_serial.sv
// Directed bench for resta_serial (N=8). Compile with +define+RESTA_OVF_EN
// to also check the signed-overflow output V.
module tb_resta_serial;
  import resta_pkg::*;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] xi;
  logic [N-1:0] yi;
  logic         busy;
  logic         done;
  logic [N-1:0] d_out;
  logic         bo;
  logic         z;
  logic         v;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;

  resta_serial #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .xi          (xi),
    .yi          (yi),
    .busy        (busy),
    .done        (done),
    .D           (d_out),
    .Bo          (bo),
    .Z           (z),
`ifdef RESTA_OVF_EN
    .V           (v),
`endif
    .dbg_state_o (dbg_state)
  );

`ifndef RESTA_OVF_EN
  assign v = 1'b0;
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset holds everything at zero even with start requested
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; xi = 8'h5A; yi = 8'h11;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00 || bo !== 1'b0 ||
          z !== 1'b0 || dbg_state !== IDLE || v !== 1'b0)
        begin errors++; $display("FAIL reset_state got busy=%b done=%b D=%h Bo=%b Z=%b V=%b st=%0d exp all 0", busy, done, d_out, bo, z, v, dbg_state); end
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE)
      begin errors++; $display("FAIL reset_release_idle got busy=%b done=%b st=%0d exp 0 0 0", busy, done, dbg_state); end
  endtask

  // One full subtraction: latency, busy width, done pulse and result hold
  task automatic test_subtract(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] exp_d, input logic exp_bo, input logic exp_z,
                               input logic exp_v);
    @(negedge clk);
    rst = 1'b0; start = 1'b1; xi = a; yi = b;
    @(posedge clk); #1;
    start = 1'b0;
    xi = N'($urandom_range(0, 255));
    yi = N'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0)
        begin errors++; $display("FAIL %s busy_cycle%0d got busy=%b done=%b exp 1 0", name, i, busy, done); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL %s done_pulse got done=%b busy=%b exp 1 0", name, done, busy); end
    checks++;
    if (d_out !== exp_d || bo !== exp_bo || z !== exp_z)
      begin errors++; $display("FAIL %s result got D=%h Bo=%b Z=%b exp D=%h Bo=%b Z=%b", name, d_out, bo, z, exp_d, exp_bo, exp_z); end
`ifdef RESTA_OVF_EN
    checks++;
    if (v !== exp_v)
      begin errors++; $display("FAIL %s ovf got V=%b exp V=%b", name, v, exp_v); end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || d_out !== exp_d || bo !== exp_bo || z !== exp_z)
      begin errors++; $display("FAIL %s hold got done=%b busy=%b D=%h Bo=%b Z=%b exp 0 0 %h %b %b", name, done, busy, d_out, bo, z, exp_d, exp_bo, exp_z); end
  endtask

  // start re-pulsed during RUN and during DONE must be ignored
  task automatic test_restart_ignored();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; xi = 8'h09; yi = 8'h04;
    @(posedge clk); #1;
    start = 1'b0; xi = 8'h77; yi = 8'h66;
    repeat (3) @(negedge clk);
    start = 1'b1; xi = 8'hFF; yi = 8'h00;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      checks++;
      if (busy !== 1'b1)
        begin errors++; $display("FAIL restart_busy%0d got busy=%b exp 1", i, busy); end
    end
    @(negedge clk);
    if (done === 1'b1) dones++;
    checks++;
    if (done !== 1'b1 || d_out !== 8'h05 || bo !== 1'b0 || z !== 1'b0)
      begin errors++; $display("FAIL restart_result got done=%b D=%h Bo=%b Z=%b exp 1 05 0 0", done, d_out, bo, z); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL restart_after_done%0d got busy=%b done=%b exp 0 0", i, busy, done); end
      @(negedge clk);
    end
    checks++;
    if (dones != 1)
      begin errors++; $display("FAIL restart_done_count got %0d exp 1", dones); end
  endtask

  // Reset in the middle of RUN aborts, then a new operation starts as rst drops
  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; xi = 8'h33; yi = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1)
      begin errors++; $display("FAIL abort_pre_busy got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00 || bo !== 1'b0 || z !== 1'b0 || dbg_state !== IDLE)
      begin errors++; $display("FAIL abort_async got busy=%b done=%b D=%h Bo=%b Z=%b st=%0d exp all 0", busy, done, d_out, bo, z, dbg_state); end
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || d_out !== 8'h00)
        begin errors++; $display("FAIL abort_held got busy=%b done=%b D=%h exp 0 0 00", busy, done, d_out); end
    end
    test_subtract("after_abort", 8'h20, 8'h01, 8'h1F, 1'b0, 1'b0, 1'b0);
  endtask

  // start held high: one acceptance every N+2 cycles
  task automatic test_back_to_back();
    logic exp_busy;
    logic exp_done;
    @(negedge clk);
    start = 1'b1; xi = 8'h05; yi = 8'h03;
    @(posedge clk);
    for (int i = 0; i < 3 * (N + 2); i++) begin
      @(negedge clk);
      exp_busy = ((i % (N + 2)) < N);
      exp_done = ((i % (N + 2)) == N);
      checks++;
      if (busy !== exp_busy || done !== exp_done)
        begin errors++; $display("FAIL b2b_cycle%0d got busy=%b done=%b exp %b %b", i, busy, done, exp_busy, exp_done); end
      if (exp_done) begin
        checks++;
        if (d_out !== 8'h02)
          begin errors++; $display("FAIL b2b_result%0d got D=%h exp 02", i, d_out); end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL b2b_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; xi = '0; yi = '0;
    test_reset();
    test_subtract("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    test_subtract("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    test_subtract("sub_A5_A5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0);
    test_subtract("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    test_subtract("sub_10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
    test_subtract("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    test_subtract("sub_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
    test_subtract("sub_FF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    test_subtract("sub_C3_3C", 8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0, 1'b0);
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
